control_puerta_ascensor: RTL

//   Elevator cabin/door controller FSM: latches floor calls, drives the hoist motor, sequences the door.

---
 rtl/control_puerta_ascensor.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/control_puerta_ascensor.sv
// -----------------------------------------------------------------------------
// control_puerta_ascensor
//
// Elevator cabin/door controller. Latches floor calls into a pending-request
// vector, moves the cabin floor by floor with the hoist motor, and sequences
// the door through arm (timer cleared) -> open (timer running) -> closing.
// It drives the start/restart inputs of a slow external door timer and
// consumes that timer's t_expired level. The ARM and CLOSING states hold
// restart_timer for HOLD_CYCLES clocks so the slow timer is sure to see it.
//
// Ports
//   clk              in   system clock (100 MHz)
//   reset            in   synchronous, active-high reset
//   call_valid       in   1-cycle strobe, call_floor carries a floor call
//   call_floor       in   requested floor index
//   floor_arrive     in   1-cycle pulse, cabin reached the next floor
//   sensor_puerta    in   1 = door obstructed
//   sensor_sobrepeso in   1 = cabin overweight
//   t_expired        in   door timer expired (level, cleared by restart)
//   start_timer      out  run door timer
//   restart_timer    out  hold door timer cleared
//   motor_up         out  hoist up
//   motor_down       out  hoist down
//   door_open        out  door actuator open
//   alarm            out  overweight alarm
//   floor_cur        out  current cabin floor (registered)
//   state            out  FSM state code (debug/observability)
//   pending          out  OR of the pending-call vector
//
// Handshake: call_valid is a single-cycle strobe with no back-pressure; the
// call is either recorded in the request vector on that clock edge or
// dropped (out-of-range floor, or the floor whose door is already open).
// -----------------------------------------------------------------------------
module control_puerta_ascensor #(
  parameter int FLOORS      = 3,
  parameter int FLOOR_W     = 2,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               call_valid,
  input  logic [FLOOR_W-1:0] call_floor,
  input  logic               floor_arrive,
  input  logic               sensor_puerta,
  input  logic               sensor_sobrepeso,
  input  logic               t_expired,
  output logic               start_timer,
  output logic               restart_timer,
  output logic               motor_up,
  output logic               motor_down,
  output logic               door_open,
  output logic               alarm,
  output logic [FLOOR_W-1:0] floor_cur,
  output logic [2:0]         state,
  output logic               pending
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_UP       = 3'd1;
  localparam logic [2:0] S_DOWN     = 3'd2;
  localparam logic [2:0] S_ARM      = 3'd3;
  localparam logic [2:0] S_OPEN     = 3'd4;
  localparam logic [2:0] S_OVERLOAD = 3'd5;
  localparam logic [2:0] S_CLOSING  = 3'd6;

  // One extra count of headroom so the counter can hold HOLD_CYCLES itself.
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_TOP = FLOOR_W'(FLOORS - 1);
  localparam logic [FLOOR_W:0]   FLOOR_LIM = (FLOOR_W + 1)'(FLOORS);

  logic [2:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [FLOOR_W-1:0] floor_q,  floor_d;
  logic [FLOORS-1:0]  req_q,    req_d;

  logic req_above;
  logic req_below;
  logic clr_en;
  logic call_ok;
  logic door_zone;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLOSING;
      cnt_q   <= '0;
      floor_q <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      floor_q <= floor_d;
      req_q   <= req_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending requests strictly above / below the current floor
  // ---------------------------------------------------------------------------
  always_comb begin
    req_above = 1'b0;
    req_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (req_q[i] && (FLOOR_W'(i) > floor_q)) req_above = 1'b1;
      if (req_q[i] && (FLOOR_W'(i) < floor_q)) req_below = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, floor, hold counter and request vector
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_q[floor_q]) begin
          state_d = S_ARM;
          clr_en  = 1'b1;
        end else if (req_above) begin
          state_d = S_UP;
        end else if (req_below) begin
          state_d = S_DOWN;
        end
      end

      S_UP: begin
        if (floor_arrive) begin
          if (floor_q != FLOOR_TOP) floor_d = floor_q + FLOOR_W'(1);
          if (req_q[floor_d]) begin
            state_d = S_ARM;
            clr_en  = 1'b1;
          end
        end
      end

      S_DOWN: begin
        if (floor_arrive) begin
          if (floor_q != '0) floor_d = floor_q - FLOOR_W'(1);
          if (req_q[floor_d]) begin
            state_d = S_ARM;
            clr_en  = 1'b1;
          end
        end
      end

      S_ARM: begin
        // An obstruction restarts the hold window from zero.
        if (sensor_sobrepeso) begin
          state_d = S_OVERLOAD;
        end else if (sensor_puerta) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_OPEN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_OPEN: begin
        if (sensor_sobrepeso)   state_d = S_OVERLOAD;
        else if (sensor_puerta) state_d = S_ARM;
        else if (t_expired)     state_d = S_CLOSING;
      end

      S_OVERLOAD: begin
        if (!sensor_sobrepeso) state_d = S_ARM;
      end

      S_CLOSING: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sensor_puerta)          state_d = S_ARM;
        else if (cnt_q == CNT_LAST) state_d = S_IDLE;
      end

      default: begin
        // Unreachable code 7: close the door safely.
        state_d = S_CLOSING;
      end
    endcase

    // The hold window always starts fresh when ARM or CLOSING is entered.
    if ((state_d != state_q) && ((state_d == S_ARM) || (state_d == S_CLOSING))) begin
      cnt_d = '0;
    end
  end

  // Calls for the floor whose door is already in use are already served.
  assign door_zone = (state_q == S_ARM) || (state_q == S_OPEN) || (state_q == S_OVERLOAD);
  assign call_ok   = call_valid && ({1'b0, call_floor} < FLOOR_LIM) &&
                     !(door_zone && (call_floor == floor_q));

  // Clearing the served floor wins over a same-cycle call for that floor:
  // the door is about to open there anyway.
  always_comb begin
    req_d = req_q;
    if (call_ok) req_d[call_floor] = 1'b1;
    if (clr_en)  req_d[floor_d]    = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    start_timer   = 1'b0;
    restart_timer = 1'b1;
    motor_up      = 1'b0;
    motor_down    = 1'b0;
    door_open     = 1'b0;
    alarm         = 1'b0;
    case (state_q)
      S_UP:       motor_up   = 1'b1;
      S_DOWN:     motor_down = 1'b1;
      S_ARM:      door_open  = 1'b1;
      S_OPEN: begin
        door_open     = 1'b1;
        start_timer   = 1'b1;
        restart_timer = 1'b0;
      end
      S_OVERLOAD: begin
        door_open = 1'b1;
        alarm     = 1'b1;
      end
      default: ;
    endcase
  end

  assign floor_cur = floor_q;
  assign state     = state_q;
  assign pending   = |req_q;

endmodule
